boreal_boot_seq: RTL and testbench

Parametrised multi-image secure-boot sequencer, successor to the single-image boot ROM check path. It walks NUM_IMAGES contiguous images in boot memory over a req/ack read port and folds each image through an internal rotate-xor digest. Word 0 of each image is its version header. It checks each digest against a per-image fuse slot and each version against an anti-rollback floor, then reports per-image and aggregate pass/fail to the reset/boot controller.

---
 rtl/boreal_boot_seq_if.sv | 14 +
 rtl/boreal_boot_seq.sv | 166 ++++++++++++++++
 tb/tb_boreal_boot_seq.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boreal_boot_seq_if.sv
// Boot-memory read port for the secure-boot sequencer: a single req/ack word read,
// where rdata is valid in the same cycle as ack.
interface boreal_boot_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_addr, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/boreal_boot_seq.sv
// Multi-image secure-boot sequencer: fetches each image, folds it into a rotate-xor digest,
// and checks it against a fuse digest and an anti-rollback version floor.
module boreal_boot_seq #(
  parameter int                NUM_IMAGES      = 2,
  parameter int                WORDS_PER_IMAGE = 4,
  parameter int                DATA_W          = 32,
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter int                ACK_TIMEOUT     = 16,
  parameter bit                STOP_ON_FAIL    = 1'b0,
  parameter logic [31:0]       HASH_INIT       = 32'h6A09E667,
  localparam int               IMG_W           = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  boreal_boot_seq_if.master            mem,
  input  logic [NUM_IMAGES*DATA_W-1:0] fuse_hash,
  input  logic [DATA_W-1:0]            fuse_min_version,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [NUM_IMAGES-1:0]        img_pass,
  output logic [1:0]                   fail_code,
  output logic [DATA_W-1:0]            digest_out,
  output logic [IMG_W-1:0]             cur_image
);

  localparam int WRD_W = $clog2(WORDS_PER_IMAGE + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] IMG_INC  = ADDR_W'(WORDS_PER_IMAGE * (DATA_W / 8));
  localparam logic [DATA_W-1:0] H_SEED   = DATA_W'(HASH_INIT);

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_HASH    = 2'd1;
  localparam logic [1:0] FC_ROLL    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, NEXT, DONE} state_t;

  state_t            state;
  logic [WRD_W-1:0]  word_idx;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] img_base;
  logic              img_fail;
  logic [DATA_W-1:0] h;
  logic [DATA_W-1:0] version;
  logic [DATA_W-1:0] slot;
  logic              hash_ok;
  logic              ver_ok;
  logic              last_word;
  logic              last_img;

  function automatic logic [DATA_W-1:0] rotl5(input logic [DATA_W-1:0] x);
    return {x[DATA_W-6:0], x[DATA_W-1:DATA_W-5]};
  endfunction

  always_comb begin
    slot = '0;
    for (int i = 0; i < NUM_IMAGES; i++)
      if (cur_image == IMG_W'(i)) slot = fuse_hash[i*DATA_W +: DATA_W];
  end

  // An all-zero fuse slot means the image digest is not provisioned and is not enforced.
  assign hash_ok   = (slot == '0) || (h == slot);
  assign ver_ok    = (version >= fuse_min_version);
  assign last_word = (word_idx == WRD_W'(WORDS_PER_IMAGE - 1));
  assign last_img  = (cur_image == IMG_W'(NUM_IMAGES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      img_pass     <= '0;
      fail_code    <= FC_NONE;
      digest_out   <= '0;
      cur_image    <= '0;
      word_idx     <= '0;
      to_cnt       <= '0;
      img_base     <= '0;
      img_fail     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= FETCH;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= BASE_ADDR;
            img_base     <= BASE_ADDR;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            img_pass     <= '0;
            fail_code    <= FC_NONE;
            digest_out   <= '0;
            cur_image    <= '0;
            word_idx     <= '0;
            to_cnt       <= '0;
            img_fail     <= 1'b0;
            h            <= H_SEED;
          end
        end

        FETCH: begin
          if (mem.mem_ack) begin
            h            <= rotl5(h) ^ mem.mem_rdata;
            if (word_idx == '0) version <= mem.mem_rdata;
            to_cnt       <= '0;
            word_idx     <= word_idx + WRD_W'(1);
            mem.mem_addr <= mem.mem_addr + WORD_INC;
            if (last_word) begin
              state       <= CHECK;
              mem.mem_req <= 1'b0;
            end
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            // Timed-out image is failed without touching digest_out.
            state               <= NEXT;
            mem.mem_req         <= 1'b0;
            to_cnt              <= '0;
            img_fail            <= 1'b1;
            img_pass[cur_image] <= 1'b0;
            if (fail_code == FC_NONE) fail_code <= FC_TIMEOUT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        CHECK: begin
          state               <= NEXT;
          digest_out          <= h;
          img_pass[cur_image] <= hash_ok && ver_ok;
          img_fail            <= !(hash_ok && ver_ok);
          if (fail_code == FC_NONE && !(hash_ok && ver_ok))
            fail_code <= hash_ok ? FC_ROLL : FC_HASH;
        end

        NEXT: begin
          if ((img_fail && STOP_ON_FAIL) || last_img) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= &img_pass;
          end else begin
            state        <= FETCH;
            cur_image    <= cur_image + IMG_W'(1);
            word_idx     <= '0;
            to_cnt       <= '0;
            img_fail     <= 1'b0;
            h            <= H_SEED;
            img_base     <= img_base + IMG_INC;
            mem.mem_addr <= img_base + IMG_INC;
            mem.mem_req  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boreal_boot_seq.sv
// Directed bench for boreal_boot_seq: three instances (W=1, W=1 stop-on-fail, W=8 with random
// ack stalls) share one boot memory and fuse inputs.
module tb_boreal_boot_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [63:0] fuse_hash = '0;
  logic [31:0] min_ver = '0;
  logic [31:0] mem [0:15];
  logic blk0_a = 1'b0;
  logic en_c = 1'b1;
  int   stall_c = 0;
  int   cnt4_b = 0;
  int   n_chk = 0, n_fail = 0;

  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [1:0]  img_a, img_b, img_c, fc_a, fc_b, fc_c;
  logic [31:0] dig_a, dig_b, dig_c;
  logic        cur_a, cur_b, cur_c;

  boreal_boot_seq_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
  boreal_boot_seq_if #(.DATA_W(32), .ADDR_W(32)) if_b ();
  boreal_boot_seq_if #(.DATA_W(32), .ADDR_W(32)) if_c ();

  assign if_a.mem_ack   = if_a.mem_req && !(blk0_a && (if_a.mem_addr < 32'd4));
  assign if_a.mem_rdata = mem[if_a.mem_addr[5:2]];
  assign if_b.mem_ack   = if_b.mem_req;
  assign if_b.mem_rdata = mem[if_b.mem_addr[5:2]];
  assign if_c.mem_ack   = if_c.mem_req && en_c;
  assign if_c.mem_rdata = mem[if_c.mem_addr[5:2]];

  boreal_boot_seq #(.NUM_IMAGES(2), .WORDS_PER_IMAGE(1), .DATA_W(32), .ADDR_W(32),
                    .BASE_ADDR(32'h0), .ACK_TIMEOUT(16), .STOP_ON_FAIL(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mem(if_a), .fuse_hash(fuse_hash),
    .fuse_min_version(min_ver), .busy(busy_a), .done(done_a), .pass(pass_a),
    .img_pass(img_a), .fail_code(fc_a), .digest_out(dig_a), .cur_image(cur_a));

  boreal_boot_seq #(.NUM_IMAGES(2), .WORDS_PER_IMAGE(1), .DATA_W(32), .ADDR_W(32),
                    .BASE_ADDR(32'h0), .ACK_TIMEOUT(16), .STOP_ON_FAIL(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mem(if_b), .fuse_hash(fuse_hash),
    .fuse_min_version(min_ver), .busy(busy_b), .done(done_b), .pass(pass_b),
    .img_pass(img_b), .fail_code(fc_b), .digest_out(dig_b), .cur_image(cur_b));

  boreal_boot_seq #(.NUM_IMAGES(2), .WORDS_PER_IMAGE(8), .DATA_W(32), .ADDR_W(32),
                    .BASE_ADDR(32'h0), .ACK_TIMEOUT(16), .STOP_ON_FAIL(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .mem(if_c), .fuse_hash(fuse_hash),
    .fuse_min_version(min_ver), .busy(busy_c), .done(done_c), .pass(pass_c),
    .img_pass(img_c), .fail_code(fc_c), .digest_out(dig_c), .cur_image(cur_c));

  always #5 clk = ~clk;

  // Random 0..5 cycle gaps between ack opportunities for the W=8 instance.
  always @(negedge clk) begin
    if (stall_c != 0) begin
      stall_c = stall_c - 1;
      en_c = 1'b0;
    end else begin
      en_c = 1'b1;
      stall_c = $urandom_range(0, 5);
    end
  end

  always @(posedge clk)
    if (if_b.mem_req && if_b.mem_addr == 32'd4) cnt4_b = cnt4_b + 1;

  function automatic logic [31:0] model(input int b, input int w);
    logic [31:0] h = 32'h6A09E667;
    for (int i = 0; i < w; i++) h = {h[26:0], h[31:27]} ^ mem[b+i];
    return h;
  endfunction

  function automatic logic dn(input int sel);
    case (sel)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input int sel);
    @(negedge clk);
    if (sel == 0) start_a = 1'b1;
    else if (sel == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int max_cyc, input string name);
    int c = 0;
    while (!dn(sel) && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    n_chk++;
    if (!dn(sel)) begin
      n_fail++;
      $display("FAIL %s: done=0 after %0d cycles, required done=1", name, c);
    end
  endtask

  task automatic set_w1(input logic [31:0] v0, input logic [31:0] v1);
    mem[0] = v0; mem[1] = v1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_chk++;
    if ({if_a.mem_req, if_a.mem_addr, busy_a, done_a, pass_a, img_a, fc_a, dig_a, cur_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: req=%b addr=%h busy=%b done=%b img=%b fc=%0d dig=%h, required all 0",
               if_a.mem_req, if_a.mem_addr, busy_a, done_a, img_a, fc_a, dig_a);
    end
    n_chk++;
    if ({if_c.mem_req, if_c.mem_addr, busy_c, done_c, pass_c, img_c, fc_c, dig_c, cur_c} !== '0) begin
      n_fail++;
      $display("FAIL reset_c: req=%b addr=%h busy=%b done=%b, required all 0",
               if_c.mem_req, if_c.mem_addr, busy_c, done_c);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    set_w1(32'd1, 32'd1); fuse_hash = '0; min_ver = '0;
    do_start(0);
    n_chk++;
    if (if_a.mem_req !== 1'b1 || if_a.mem_addr !== 32'd0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_req0: req=%b addr=%h busy=%b, required 1/0/1", if_a.mem_req, if_a.mem_addr, busy_a);
    end
    cyc(3);
    n_chk++;
    if (if_a.mem_req !== 1'b1 || if_a.mem_addr !== 32'd4 || cur_a !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_req1: req=%b addr=%h cur=%b, required 1/4/1", if_a.mem_req, if_a.mem_addr, cur_a);
    end
    cyc(2);
    n_chk++;
    if (done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_early: done=%b at 5 cycles, required 0", done_a);
    end
    cyc(1);
    n_chk++;
    if (done_a !== 1'b1 || pass_a !== 1'b1 || img_a !== 2'b11 || fc_a !== 2'd0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: done=%b pass=%b img=%b fc=%0d busy=%b, required 1/1/11/0/0",
               done_a, pass_a, img_a, fc_a, busy_a);
    end
    n_chk++;
    if (dig_a !== 32'h413CCCEC) begin
      n_fail++;
      $display("FAIL basic_digest: got %h, required 413ccced^1=413ccceC", dig_a);
    end
  endtask

  task automatic test_hash_mismatch();
    set_w1(32'd1, 32'd1); min_ver = '0;
    fuse_hash = {32'hDEADBEEF, 32'h413CCCEC};
    do_start(0);
    wait_done(0, 20, "hash_done");
    n_chk++;
    if (img_a !== 2'b01 || pass_a !== 1'b0 || fc_a !== 2'd1) begin
      n_fail++;
      $display("FAIL hash_mismatch: img=%b pass=%b fc=%0d, required 01/0/1", img_a, pass_a, fc_a);
    end
    fuse_hash = '0;
  endtask

  task automatic test_rollback();
    set_w1(32'd1, 32'd3); min_ver = 32'd2; fuse_hash = '0;
    do_start(0);
    wait_done(0, 20, "rollback_done");
    n_chk++;
    if (img_a !== 2'b10 || pass_a !== 1'b0 || fc_a !== 2'd2) begin
      n_fail++;
      $display("FAIL rollback: img=%b pass=%b fc=%0d, required 10/0/2", img_a, pass_a, fc_a);
    end
  endtask

  task automatic test_stop_on_fail();
    int seen;
    set_w1(32'd1, 32'd3); min_ver = 32'd2; fuse_hash = '0;
    seen = cnt4_b;
    do_start(1);
    cyc(2);
    n_chk++;
    if (done_b !== 1'b0) begin
      n_fail++;
      $display("FAIL sof_done_early: done=%b at 2 cycles, required 0", done_b);
    end
    cyc(1);
    n_chk++;
    if (done_b !== 1'b1 || img_b !== 2'b00 || fc_b !== 2'd2 || pass_b !== 1'b0) begin
      n_fail++;
      $display("FAIL sof_result: done=%b img=%b fc=%0d pass=%b, required 1/00/2/0", done_b, img_b, fc_b, pass_b);
    end
    cyc(3);
    n_chk++;
    if (cnt4_b != seen) begin
      n_fail++;
      $display("FAIL sof_addr4: addr 4 requested %0d times, required 0", cnt4_b - seen);
    end
    min_ver = '0;
  endtask

  task automatic test_timeout();
    set_w1(32'd1, 32'd1); min_ver = '0; fuse_hash = '0;
    blk0_a = 1'b1;
    do_start(0);
    cyc(15);
    n_chk++;
    if (fc_a !== 2'd0 || busy_a !== 1'b1 || if_a.mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_early: fc=%0d busy=%b addr=%h after 15 stalls, required 0/1/0", fc_a, busy_a, if_a.mem_addr);
    end
    cyc(1);
    n_chk++;
    if (fc_a !== 2'd3 || img_a[0] !== 1'b0 || dig_a !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_hit: fc=%0d img0=%b dig=%h after 16 stalls, required 3/0/0", fc_a, img_a[0], dig_a);
    end
    wait_done(0, 10, "timeout_done");
    n_chk++;
    if (img_a !== 2'b10 || fc_a !== 2'd3 || pass_a !== 1'b0 || dig_a !== 32'h413CCCEC) begin
      n_fail++;
      $display("FAIL timeout_result: img=%b fc=%0d pass=%b dig=%h, required 10/3/0/413ccceC", img_a, fc_a, pass_a, dig_a);
    end
    blk0_a = 1'b0;
  endtask

  task automatic test_abort();
    set_w1(32'd1, 32'd1);
    blk0_a = 1'b1;
    do_start(0);
    cyc(2);
    n_chk++;
    if (busy_a !== 1'b1 || if_a.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: busy=%b req=%b, required 1/1", busy_a, if_a.mem_req);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({if_a.mem_req, if_a.mem_addr, busy_a, done_a, pass_a, img_a, fc_a, dig_a, cur_a} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset: req=%b busy=%b done=%b img=%b fc=%0d, required all 0",
               if_a.mem_req, busy_a, done_a, img_a, fc_a);
    end
    @(negedge clk); rst = 1'b0; blk0_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_w1(32'd1, 32'd1); fuse_hash = '0; min_ver = '0;
    do_start(0);
    cyc(2);
    do_start(0);
    cyc(2);
    n_chk++;
    if (done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_early: done=%b at 5 cycles, required 0", done_a);
    end
    cyc(1);
    n_chk++;
    if (done_a !== 1'b1 || img_a !== 2'b11) begin
      n_fail++;
      $display("FAIL busy_start_ignored: done=%b img=%b at 6 cycles, required 1/11", done_a, img_a);
    end
    do_start(0);
    n_chk++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_clear: done=%b busy=%b, required 0/1", done_a, busy_a);
    end
    wait_done(0, 20, "rerun_done");
    n_chk++;
    if (img_a !== 2'b11 || pass_a !== 1'b1 || fc_a !== 2'd0 || dig_a !== 32'h413CCCEC) begin
      n_fail++;
      $display("FAIL rerun_result: img=%b pass=%b fc=%0d dig=%h, required 11/1/0/413ccceC", img_a, pass_a, fc_a, dig_a);
    end
  endtask

  task automatic test_random_w8();
    logic [31:0] m0, m1;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'd5; mem[8] = 32'd7;
    m0 = model(0, 8); m1 = model(8, 8);
    min_ver = 32'd6; fuse_hash = {m1, m0};
    do_start(2);
    wait_done(2, 300, "w8_run1_done");
    n_chk++;
    if (img_c !== 2'b10 || fc_c !== 2'd2 || dig_c !== m1 || pass_c !== 1'b0) begin
      n_fail++;
      $display("FAIL w8_run1: img=%b fc=%0d dig=%h pass=%b, required 10/2/%h/0", img_c, fc_c, dig_c, pass_c, m1);
    end
    min_ver = '0; fuse_hash = {m1 ^ 32'd1, m0};
    do_start(2);
    wait_done(2, 300, "w8_run2_done");
    n_chk++;
    if (img_c !== 2'b01 || fc_c !== 2'd1 || dig_c !== m1 || pass_c !== 1'b0) begin
      n_fail++;
      $display("FAIL w8_run2: img=%b fc=%0d dig=%h pass=%b, required 01/1/%h/0", img_c, fc_c, dig_c, pass_c, m1);
    end
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'd9; mem[8] = 32'd0;
    m0 = model(0, 8); m1 = model(8, 8);
    fuse_hash = {m1, m0};
    do_start(2);
    wait_done(2, 300, "w8_run3_done");
    n_chk++;
    if (img_c !== 2'b11 || fc_c !== 2'd0 || dig_c !== m1 || pass_c !== 1'b1) begin
      n_fail++;
      $display("FAIL w8_run3: img=%b fc=%0d dig=%h pass=%b, required 11/0/%h/1", img_c, fc_c, dig_c, pass_c, m1);
    end
    fuse_hash = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_hash_mismatch();
    test_rollback();
    test_stop_on_fail();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random_w8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
